// File: rtl/crypto_acc_mmio.sv
// Memory-mapped front end for the crypto accelerator: register file, key/data/result buffers
// and a block sequencer that streams BLK_WORDS-word blocks to the cipher core and collects results.
module crypto_acc_mmio #(
   parameter int BUS_WIDTH = 32,
   parameter int KEY_WORDS = 8,
   parameter int BUF_WORDS = 64,
   parameter int BLK_WORDS = 4
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           read_en_i,
   input  logic                           write_en_i,
   input  logic [BUS_WIDTH-1:0]           addr_i,
   input  logic [BUS_WIDTH-1:0]           data_i,
   output logic [BUS_WIDTH-1:0]           data_o,
   output logic                           rd_valid_o,
   output logic                           irq_o,
   output logic [KEY_WORDS*BUS_WIDTH-1:0] core_key_o,
   output logic [3:0]                     core_klen_o,
   output logic                           core_valid_o,
   output logic [BLK_WORDS*BUS_WIDTH-1:0] core_blk_o,
   input  logic                           core_ready_i,
   input  logic                           core_res_valid_i,
   input  logic [BLK_WORDS*BUS_WIDTH-1:0] core_res_i
);

   localparam int AW  = (BUF_WORDS > 1) ? $clog2(BUF_WORDS) : 1;
   localparam int PW  = AW + 1;
   localparam int KAW = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;
   localparam int WW  = (BLK_WORDS > 1) ? $clog2(BLK_WORDS) : 1;
   localparam logic [WW-1:0] LAST_WORD = WW'(BLK_WORDS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SEND,
      S_WAIT,
      S_STORE,
      S_FIN
   } state_t;

   state_t state, state_nxt;

   logic [BUS_WIDTH-1:0] key_buf    [KEY_WORDS];
   logic [BUS_WIDTH-1:0] data_buf   [BUF_WORDS];
   logic [BUS_WIDTH-1:0] result_buf [BUF_WORDS];

   logic                 irq_en, done, err;
   logic [BUS_WIDTH-1:0] key_len, data_len, result_len;
   logic [3:0]           klen_lat;
   logic [PW-1:0]        base_ptr, buf_idx;
   logic [WW-1:0]        wcnt;
   logic [BLK_WORDS*BUS_WIDTH-1:0] blk_reg, res_reg;
   logic [BUS_WIDTH-1:0] rd_data;

   logic [3:0]  region;
   logic [11:0] idx;
   logic sel_ctrl, sel_status, sel_klen, sel_dlen, sel_rlen;
   logic key_hit, data_hit, res_hit;
   logic busy, cfg_ok, start_req, key_wr, data_wr, more_blocks;
   logic unused_ok;

   assign region     = addr_i[15:12];
   assign idx        = addr_i[11:0];
   assign sel_ctrl   = (addr_i[15:0] == 16'h0000);
   assign sel_status = (addr_i[15:0] == 16'h0001);
   assign sel_klen   = (addr_i[15:0] == 16'h0101);
   assign sel_dlen   = (addr_i[15:0] == 16'h0102);
   assign sel_rlen   = (addr_i[15:0] == 16'h0103);
   assign key_hit    = (region == 4'h1) && (idx < 12'(KEY_WORDS));
   assign data_hit   = (region == 4'h2) && (idx < 12'(BUF_WORDS));
   assign res_hit    = (region == 4'h3) && (idx < 12'(BUF_WORDS));

   assign busy      = (state != S_IDLE);
   assign cfg_ok    = (key_len >= BUS_WIDTH'(1)) && (key_len <= BUS_WIDTH'(KEY_WORDS)) &&
                      (data_len != '0) && ((data_len % BUS_WIDTH'(BLK_WORDS)) == '0) &&
                      (data_len <= BUS_WIDTH'(BUF_WORDS));
   assign start_req = write_en_i && sel_ctrl && data_i[0] && (state == S_IDLE);
   assign key_wr    = write_en_i && key_hit && !busy;
   assign data_wr   = write_en_i && data_hit && !busy;

   assign buf_idx     = base_ptr + PW'(wcnt);
   assign more_blocks = (BUS_WIDTH'(base_ptr) + BUS_WIDTH'(BLK_WORDS)) < data_len;

   assign irq_o        = done & irq_en;
   assign core_valid_o = (state == S_SEND);
   assign core_blk_o   = blk_reg;
   assign core_klen_o  = klen_lat;
   assign unused_ok    = ^{addr_i[BUS_WIDTH-1:16], buf_idx[PW-1:AW]};

   always_comb begin
      core_key_o = '0;
      for (int k = 0; k < KEY_WORDS; k++) begin
         core_key_o[k*BUS_WIDTH +: BUS_WIDTH] = key_buf[k];
      end
   end

   // Read mux sees pre-edge state, so a same-cycle write is not visible to the read.
   always_comb begin
      rd_data = '0;
      if (sel_ctrl)        rd_data[1]   = irq_en;
      else if (sel_status) rd_data[2:0] = {err, done, busy};
      else if (sel_klen)   rd_data      = key_len;
      else if (sel_dlen)   rd_data      = data_len;
      else if (sel_rlen)   rd_data      = result_len;
      else if (key_hit)    rd_data      = key_buf[addr_i[KAW-1:0]];
      else if (data_hit)   rd_data      = data_buf[addr_i[AW-1:0]];
      else if (res_hit)    rd_data      = result_buf[addr_i[AW-1:0]];
   end

   // Register file and status flags; FIN's DONE set is placed last so it beats a W1C.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         irq_en     <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         key_len    <= '0;
         data_len   <= '0;
         result_len <= '0;
         klen_lat   <= '0;
         data_o     <= '0;
         rd_valid_o <= 1'b0;
      end else begin
         rd_valid_o <= read_en_i;
         if (read_en_i) data_o <= rd_data;
         if (write_en_i) begin
            if (sel_ctrl) irq_en <= data_i[1];
            if (sel_status) begin
               if (data_i[1]) done <= 1'b0;
               if (data_i[2]) err  <= 1'b0;
            end
            if (sel_klen) begin
               if (busy) err <= 1'b1;
               else      key_len <= data_i;
            end
            if (sel_dlen) begin
               if (busy) err <= 1'b1;
               else      data_len <= data_i;
            end
            if (busy && ((region == 4'h1) || (region == 4'h2))) err <= 1'b1;
         end
         if (start_req) begin
            if (cfg_ok) begin
               done     <= 1'b0;
               klen_lat <= key_len[3:0];
            end else begin
               err <= 1'b1;
            end
         end
         if (state == S_FIN) begin
            done       <= 1'b1;
            result_len <= data_len;
         end
      end
   end

   // Buffers are plain storage and deliberately survive reset.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         if (key_wr)  key_buf[addr_i[KAW-1:0]] <= data_i;
         if (data_wr) data_buf[addr_i[AW-1:0]] <= data_i;
         if (state == S_STORE)
            result_buf[buf_idx[AW-1:0]] <= res_reg[int'(wcnt)*BUS_WIDTH +: BUS_WIDTH];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start_req && cfg_ok) state_nxt = S_LOAD;
         S_LOAD:  if (wcnt == LAST_WORD) state_nxt = S_SEND;
         S_SEND:  if (core_ready_i) state_nxt = S_WAIT;
         S_WAIT:  if (core_res_valid_i) state_nxt = S_STORE;
         S_STORE: if (wcnt == LAST_WORD) state_nxt = more_blocks ? S_LOAD : S_FIN;
         S_FIN:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Sequencer datapath: word counter walks each block, base pointer advances per block.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         base_ptr <= '0;
         wcnt     <= '0;
         blk_reg  <= '0;
         res_reg  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_req && cfg_ok) begin
                  base_ptr <= '0;
                  wcnt     <= '0;
               end
            end
            S_LOAD: begin
               blk_reg[int'(wcnt)*BUS_WIDTH +: BUS_WIDTH] <= data_buf[buf_idx[AW-1:0]];
               wcnt <= (wcnt == LAST_WORD) ? '0 : wcnt + 1'b1;
            end
            S_WAIT: begin
               if (core_res_valid_i) res_reg <= core_res_i;
            end
            S_STORE: begin
               wcnt <= (wcnt == LAST_WORD) ? '0 : wcnt + 1'b1;
               if (wcnt == LAST_WORD) base_ptr <= base_ptr + PW'(BLK_WORDS);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_crypto_acc_mmio.sv
// Directed bench for crypto_acc_mmio with an echo-style core model (result = block XOR all-ones).
module tb_crypto_acc_mmio;

   logic         clk = 1'b0;
   logic         rst_i = 1'b1;
   logic         read_en_i = 1'b0;
   logic         write_en_i = 1'b0;
   logic [31:0]  addr_i = '0;
   logic [31:0]  data_i = '0;
   logic [31:0]  data_o;
   logic         rd_valid_o;
   logic         irq_o;
   logic [255:0] core_key_o;
   logic [3:0]   core_klen_o;
   logic         core_valid_o;
   logic [127:0] core_blk_o;
   logic         core_ready_i = 1'b0;
   logic         core_res_valid_i = 1'b0;
   logic [127:0] core_res_i = '0;

   int total = 0;
   int bad = 0;

   int stall_cycles = 0;
   int stall_cnt = 0;
   int hs_count = 0;
   int valid_cycles = 0;
   bit unstable = 0;
   bit in_send = 0;
   bit pend = 0;
   logic [127:0] pend_data = '0;
   logic [127:0] snap = '0;

   crypto_acc_mmio dut (
      .clk_i(clk),
      .rst_i(rst_i),
      .read_en_i(read_en_i),
      .write_en_i(write_en_i),
      .addr_i(addr_i),
      .data_i(data_i),
      .data_o(data_o),
      .rd_valid_o(rd_valid_o),
      .irq_o(irq_o),
      .core_key_o(core_key_o),
      .core_klen_o(core_klen_o),
      .core_valid_o(core_valid_o),
      .core_blk_o(core_blk_o),
      .core_ready_i(core_ready_i),
      .core_res_valid_i(core_res_valid_i),
      .core_res_i(core_res_i)
   );

   always #5 clk = ~clk;

   // Core model: stalls ready for stall_cycles, then accepts and returns the result next cycle.
   always @(negedge clk) begin
      core_res_valid_i = pend;
      core_res_i       = pend_data;
      pend             = 0;
      core_ready_i     = 1'b0;
      if (core_valid_o) begin
         valid_cycles++;
         if (!in_send) begin
            snap    = core_blk_o;
            in_send = 1;
         end else if (core_blk_o !== snap) begin
            unstable = 1;
         end
         if (stall_cnt >= stall_cycles) begin
            core_ready_i = 1'b1;
            pend         = 1;
            pend_data    = core_blk_o ^ {128{1'b1}};
            hs_count++;
            stall_cnt    = 0;
            in_send      = 0;
         end else begin
            stall_cnt++;
         end
      end else begin
         stall_cnt = 0;
         in_send   = 0;
      end
   end

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      write_en_i = 1'b1; addr_i = a; data_i = d;
      @(negedge clk);
      write_en_i = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic v);
      @(negedge clk);
      read_en_i = 1'b1; addr_i = a;
      @(negedge clk);
      read_en_i = 1'b0;
      d = data_o;
      v = rd_valid_o;
   endtask

   task automatic wait_done(input int budget, output int cycles);
      cycles = 0;
      while (!irq_o && cycles < budget) begin
         @(negedge clk);
         cycles++;
      end
   endtask

   task automatic test_reset();
      logic [31:0] d;
      logic v;
      total++;
      if (rd_valid_o !== 1'b0 || data_o !== 32'h0) begin
         bad++; $display("[TB] FAIL reset_rd: data_o=%h rd_valid=%b exp 0/0", data_o, rd_valid_o);
      end
      total++;
      if (irq_o !== 1'b0 || core_valid_o !== 1'b0) begin
         bad++; $display("[TB] FAIL reset_out: irq=%b core_valid=%b exp 0/0", irq_o, core_valid_o);
      end
      bus_read(32'h0000, d, v);
      total++;
      if (d !== 32'h0 || v !== 1'b1) begin bad++; $display("[TB] FAIL reset_ctrl: got %h v=%b exp 0 v=1", d, v); end
      bus_read(32'h0001, d, v);
      total++;
      if (d !== 32'h0) begin bad++; $display("[TB] FAIL reset_status: got %h exp 0", d); end
      bus_read(32'h0101, d, v);
      total++;
      if (d !== 32'h0) begin bad++; $display("[TB] FAIL reset_keylen: got %h exp 0", d); end
      bus_read(32'h0103, d, v);
      total++;
      if (d !== 32'h0) begin bad++; $display("[TB] FAIL reset_reslen: got %h exp 0", d); end
   endtask

   task automatic test_single_block();
      logic [31:0] d;
      logic v;
      int cyc;
      for (int i = 0; i < 4; i++) bus_write(32'h1000 + i, 32'hA0 + i);
      bus_write(32'h0101, 32'd4);
      bus_write(32'h0102, 32'd4);
      for (int i = 0; i < 4; i++) bus_write(32'h2000 + i, i);
      bus_write(32'h0000, 32'h3);
      wait_done(200, cyc);
      total++;
      if (cyc !== 11) begin bad++; $display("[TB] FAIL single_latency: got %0d cycles exp 11", cyc); end
      total++;
      if (irq_o !== 1'b1) begin bad++; $display("[TB] FAIL single_irq: got %b exp 1", irq_o); end
      total++;
      if (core_klen_o !== 4'd4) begin bad++; $display("[TB] FAIL single_klen: got %0d exp 4", core_klen_o); end
      total++;
      if (core_key_o[31:0] !== 32'hA0 || core_key_o[127:96] !== 32'hA3) begin
         bad++; $display("[TB] FAIL single_key: w0=%h w3=%h exp a0/a3", core_key_o[31:0], core_key_o[127:96]);
      end
      bus_read(32'h0001, d, v);
      total++;
      if (d !== 32'h2) begin bad++; $display("[TB] FAIL single_status: got %h exp 2", d); end
      bus_read(32'h0000, d, v);
      total++;
      if (d !== 32'h2) begin bad++; $display("[TB] FAIL single_ctrl: got %h exp 2", d); end
      bus_read(32'h0103, d, v);
      total++;
      if (d !== 32'd4) begin bad++; $display("[TB] FAIL single_reslen: got %h exp 4", d); end
      for (int i = 0; i < 4; i++) begin
         bus_read(32'h3000 + i, d, v);
         total++;
         if (d !== (32'hFFFFFFFF - i)) begin
            bad++; $display("[TB] FAIL single_res%0d: got %h exp %h", i, d, 32'hFFFFFFFF - i);
         end
      end
      bus_write(32'h0001, 32'h2);
      bus_read(32'h0001, d, v);
      total++;
      if (d !== 32'h0 || irq_o !== 1'b0) begin
         bad++; $display("[TB] FAIL single_w1c: status=%h irq=%b exp 0/0", d, irq_o);
      end
   endtask

   task automatic test_stall_full();
      logic [31:0] d;
      logic v;
      int cyc, hs0, errs;
      stall_cycles = 5;
      unstable = 0;
      for (int i = 0; i < 64; i++) bus_write(32'h2000 + i, 32'h1000 + i);
      bus_write(32'h0102, 32'd64);
      hs0 = hs_count;
      bus_write(32'h0000, 32'h3);
      wait_done(3000, cyc);
      total++;
      if (cyc !== 241) begin bad++; $display("[TB] FAIL stall_latency: got %0d cycles exp 241", cyc); end
      total++;
      if (hs_count - hs0 !== 16) begin bad++; $display("[TB] FAIL stall_handshakes: got %0d exp 16", hs_count - hs0); end
      total++;
      if (unstable !== 1'b0) begin bad++; $display("[TB] FAIL stall_blk_stable: got unstable=%b exp 0", unstable); end
      errs = 0;
      for (int i = 0; i < 64; i++) begin
         bus_read(32'h3000 + i, d, v);
         total++;
         if (d !== ~(32'h1000 + i)) begin
            bad++; errs++;
            if (errs < 5) $display("[TB] FAIL stall_res%0d: got %h exp %h", i, d, ~(32'h1000 + i));
         end
      end
      bus_read(32'h0103, d, v);
      total++;
      if (d !== 32'd64) begin bad++; $display("[TB] FAIL stall_reslen: got %0d exp 64", d); end
      bus_write(32'h0001, 32'h6);
      stall_cycles = 0;
   endtask

   task automatic test_config_errors();
      logic [31:0] d;
      logic v;
      int vc0;
      logic [31:0] klen [3];
      logic [31:0] dlen [3];
      klen[0] = 32'd4; dlen[0] = 32'd6;
      klen[1] = 32'd4; dlen[1] = 32'd0;
      klen[2] = 32'd9; dlen[2] = 32'd4;
      vc0 = valid_cycles;
      for (int t = 0; t < 3; t++) begin
         bus_write(32'h0101, klen[t]);
         bus_write(32'h0102, dlen[t]);
         bus_write(32'h0000, 32'h3);
         bus_read(32'h0001, d, v);
         total++;
         if (d !== 32'h4) begin bad++; $display("[TB] FAIL cfg_err%0d: status=%h exp 4", t, d); end
         bus_write(32'h0001, 32'h4);
         bus_read(32'h0001, d, v);
         total++;
         if (d !== 32'h0) begin bad++; $display("[TB] FAIL cfg_w1c%0d: status=%h exp 0", t, d); end
      end
      total++;
      if (valid_cycles !== vc0) begin bad++; $display("[TB] FAIL cfg_no_valid: got %0d valid cycles exp 0", valid_cycles - vc0); end
      bus_read(32'h0103, d, v);
      total++;
      if (d !== 32'd64) begin bad++; $display("[TB] FAIL cfg_reslen: got %0d exp 64", d); end
   endtask

   task automatic test_busy_writes();
      logic [31:0] d;
      logic v;
      int cyc;
      stall_cycles = 30;
      bus_write(32'h0101, 32'd4);
      bus_write(32'h0102, 32'd16);
      for (int i = 0; i < 16; i++) bus_write(32'h2000 + i, 32'h300 + i);
      bus_write(32'h0000, 32'h3);
      bus_write(32'h2000, 32'hDEAD);
      bus_write(32'h0102, 32'd8);
      bus_read(32'h0001, d, v);
      total++;
      if (d !== 32'h5) begin bad++; $display("[TB] FAIL busy_err: status=%h exp 5", d); end
      bus_read(32'h0102, d, v);
      total++;
      if (d !== 32'd16) begin bad++; $display("[TB] FAIL busy_dlen: got %0d exp 16", d); end
      bus_read(32'h2000, d, v);
      total++;
      if (d !== 32'h300) begin bad++; $display("[TB] FAIL busy_data0: got %h exp 300", d); end
      bus_write(32'h0001, 32'h4);
      bus_write(32'h0000, 32'h3);
      bus_read(32'h0001, d, v);
      total++;
      if (d !== 32'h1) begin bad++; $display("[TB] FAIL busy_w1c_start: status=%h exp 1", d); end
      wait_done(1000, cyc);
      total++;
      if (cyc >= 1000) begin bad++; $display("[TB] FAIL busy_done_timeout: waited %0d cycles", cyc); end
      bus_read(32'h3000, d, v);
      total++;
      if (d !== ~32'h300) begin bad++; $display("[TB] FAIL busy_res0: got %h exp %h", d, ~32'h300); end
      bus_read(32'h300F, d, v);
      total++;
      if (d !== ~32'h30F) begin bad++; $display("[TB] FAIL busy_res15: got %h exp %h", d, ~32'h30F); end
      stall_cycles = 0;
   endtask

   task automatic test_reset_abort();
      logic [31:0] d;
      logic v;
      int cyc, target, n;
      for (int i = 0; i < 16; i++) bus_write(32'h2000 + i, 32'h400 + i);
      target = hs_count + 2;
      bus_write(32'h0000, 32'h3);
      n = 0;
      do begin
         @(posedge clk);
         n++;
      end while (hs_count < target && n < 500);
      total++;
      if (n >= 500) begin bad++; $display("[TB] FAIL abort_timeout: handshakes=%0d exp %0d", hs_count, target); end
      #1 rst_i = 1'b1;
      @(posedge clk);
      #1 rst_i = 1'b0;
      @(negedge clk);
      total++;
      if (core_valid_o !== 1'b0 || irq_o !== 1'b0) begin
         bad++; $display("[TB] FAIL abort_out: core_valid=%b irq=%b exp 0/0", core_valid_o, irq_o);
      end
      bus_read(32'h0001, d, v);
      total++;
      if (d !== 32'h0) begin bad++; $display("[TB] FAIL abort_status: got %h exp 0", d); end
      bus_read(32'h0103, d, v);
      total++;
      if (d !== 32'h0) begin bad++; $display("[TB] FAIL abort_reslen: got %h exp 0", d); end
      bus_read(32'h3000, d, v);
      total++;
      if (d !== ~32'h400) begin bad++; $display("[TB] FAIL abort_res0: got %h exp %h", d, ~32'h400); end
      bus_read(32'h3004, d, v);
      total++;
      if (d !== ~32'h304) begin bad++; $display("[TB] FAIL abort_res4_old: got %h exp %h", d, ~32'h304); end
      bus_write(32'h0101, 32'd4);
      bus_write(32'h0102, 32'd8);
      bus_write(32'h0000, 32'h3);
      wait_done(500, cyc);
      total++;
      if (cyc !== 21) begin bad++; $display("[TB] FAIL restart_latency: got %0d cycles exp 21", cyc); end
      bus_read(32'h3007, d, v);
      total++;
      if (d !== ~32'h407) begin bad++; $display("[TB] FAIL restart_res7: got %h exp %h", d, ~32'h407); end
      bus_read(32'h0103, d, v);
      total++;
      if (d !== 32'd8) begin bad++; $display("[TB] FAIL restart_reslen: got %0d exp 8", d); end
   endtask

   task automatic test_read_edges();
      logic [31:0] d;
      logic v;
      bus_read(32'h4000, d, v);
      total++;
      if (d !== 32'h0 || v !== 1'b1) begin bad++; $display("[TB] FAIL unmapped_rd: got %h v=%b exp 0 v=1", d, v); end
      bus_write(32'h2040, 32'h55);
      bus_read(32'h2040, d, v);
      total++;
      if (d !== 32'h0 || v !== 1'b1) begin bad++; $display("[TB] FAIL data64_rd: got %h v=%b exp 0 v=1", d, v); end
      bus_read(32'h1008, d, v);
      total++;
      if (d !== 32'h0) begin bad++; $display("[TB] FAIL key8_rd: got %h exp 0", d); end
      bus_write(32'h0103, 32'h99);
      bus_read(32'h0103, d, v);
      total++;
      if (d !== 32'd8) begin bad++; $display("[TB] FAIL reslen_ro: got %h exp 8", d); end
      @(negedge clk);
      read_en_i = 1'b1; write_en_i = 1'b1; addr_i = 32'h0101; data_i = 32'd7;
      @(negedge clk);
      read_en_i = 1'b0; write_en_i = 1'b0;
      total++;
      if (data_o !== 32'd4 || rd_valid_o !== 1'b1) begin
         bad++; $display("[TB] FAIL rw_same_cycle: got %h v=%b exp 4 v=1", data_o, rd_valid_o);
      end
      @(negedge clk);
      total++;
      if (rd_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL rd_valid_pulse: got %b exp 0", rd_valid_o); end
      bus_read(32'h0101, d, v);
      total++;
      if (d !== 32'd7) begin bad++; $display("[TB] FAIL keylen_new: got %0d exp 7", d); end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_i = 1'b0;
      test_reset();
      test_single_block();
      test_stall_full();
      test_config_errors();
      test_busy_writes();
      test_reset_abort();
      test_read_edges();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
